// File: rtl/pipe_regs.sv
// pipe_regs: WIDTH-bit, DEPTH-stage delay line with per-stage valid, enable and flush; PIPE_OCC_EN adds an occupancy counter
module pipe_regs #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
`ifdef PIPE_OCC_EN
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
`else
  output logic [WIDTH-1:0] out_data
`endif
);
  localparam int TOT = DEPTH * WIDTH;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  // flush clears valids but leaves data in place; en shifts everything one stage toward the output
  always_comb begin
    data_d  = (en && !flush) ? ((data_q << WIDTH) | TOT'(in_data)) : data_q;
    valid_d = flush ? '0 : en ? ((valid_q << 1) | DEPTH'(in_valid)) : valid_q;
  end
  // stage registers; reset zeroes both data and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
`ifdef PIPE_OCC_EN
  logic [CNT_W-1:0] occ_q, occ_d;
  // count tracks the valid bits: a beat enters at stage 0 and leaves from the last stage
  always_comb begin
    occ_d = flush ? '0 : en ? occ_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]) : occ_q;
  end
  // occupancy register, updated alongside the valid bits
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end
  assign occupancy = occ_q;
`else
`endif
endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: directed checks of pipe_regs at WIDTH=8, DEPTH=3
module tb_pipe_regs;
  logic       clk = 0;
  logic       rst, en, flush, in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  int         checks = 0;
  int         failures = 0;
`ifdef PIPE_OCC_EN
  logic [1:0] occupancy;
`endif

  pipe_regs #(.WIDTH(8), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid),
`ifdef PIPE_OCC_EN
    .out_data(out_data),
    .occupancy(occupancy)
`else
    .out_data(out_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef PIPE_OCC_EN
    chk(tag, 32'(occupancy), 32'(exp));
`endif
  endtask

  task automatic out(input string tag, input logic v, input logic [7:0] d, input int occ);
    chk({tag, "_v"}, 32'(out_valid), 32'(v));
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    chk_occ({tag, "_occ"}, occ);
  endtask

  task automatic cyc(input logic r, input logic e, input logic f, input logic v, input logic [7:0] d);
    rst = r; en = e; flush = f; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with active inputs
    cyc(1, 1, 0, 1, 8'hFF); out("rst1", 0, 8'h00, 0);
    cyc(1, 1, 0, 1, 8'hFF); out("rst2", 0, 8'h00, 0);
    // latency of three enabled edges
    cyc(0, 1, 0, 1, 8'h11); out("lat1", 0, 8'h00, 1);
    cyc(0, 1, 0, 1, 8'h22); out("lat2", 0, 8'h00, 2);
    cyc(0, 1, 0, 1, 8'h33); out("lat3", 1, 8'h11, 3);
    cyc(0, 1, 0, 1, 8'h44); out("lat4", 1, 8'h22, 3);
    cyc(0, 1, 0, 1, 8'h55); out("lat5", 1, 8'h33, 3);
    // stall: load A1, A2 then hold for five cycles
    cyc(0, 1, 0, 1, 8'hA1); out("ld1", 1, 8'h44, 3);
    cyc(0, 1, 0, 1, 8'hA2); out("ld2", 1, 8'h55, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 8'hEE); out("stall", 1, 8'h55, 3);
    end
    cyc(0, 1, 0, 0, 8'h00); out("res1", 1, 8'hA1, 2);
    cyc(0, 1, 0, 0, 8'h00); out("res2", 1, 8'hA2, 1);
    cyc(0, 1, 0, 0, 8'h00); out("res3", 0, 8'h00, 0);
    // bubbles: invalid beat still carries its data through
    cyc(0, 1, 0, 1, 8'h01); out("bub1", 0, 8'h00, 1);
    cyc(0, 1, 0, 0, 8'h02); out("bub2", 0, 8'h00, 1);
    cyc(0, 1, 0, 1, 8'h03); out("bub3", 1, 8'h01, 2);
    cyc(0, 1, 0, 0, 8'h00); out("bub4", 0, 8'h02, 1);
    cyc(0, 1, 0, 0, 8'h00); out("bub5", 1, 8'h03, 1);
    cyc(0, 1, 0, 0, 8'h00); out("bub6", 0, 8'h00, 0);
    // flush beats enable; data held, not shifted
    cyc(0, 1, 0, 1, 8'hB1);
    cyc(0, 1, 0, 1, 8'hB2);
    cyc(0, 1, 0, 1, 8'hB3); out("full", 1, 8'hB1, 3);
    cyc(0, 1, 1, 1, 8'h55); out("fl", 0, 8'hB1, 0);
    cyc(0, 1, 0, 0, 8'h00); out("fl1", 0, 8'hB2, 0);
    cyc(0, 1, 0, 0, 8'h00); out("fl2", 0, 8'hB3, 0);
    cyc(0, 1, 0, 0, 8'h00); out("fl3", 0, 8'h00, 0);
    // reset mid-stream
    cyc(0, 1, 0, 1, 8'hC1);
    cyc(0, 1, 0, 1, 8'hC2); chk_occ("pre_rst_occ", 2);
    cyc(1, 1, 0, 1, 8'h77); out("mrst", 0, 8'h00, 0);
    cyc(0, 1, 0, 1, 8'hD1); out("post1", 0, 8'h00, 1);
    cyc(0, 1, 0, 0, 8'h00); out("post2", 0, 8'h00, 1);
    cyc(0, 1, 0, 0, 8'h00); out("post3", 1, 8'hD1, 1);
    cyc(0, 1, 0, 0, 8'h00); out("post4", 0, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
